// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdf_stage_ctrl
// Purpose  : Sample-counter sequencer for one radix-2^2 SDF stage pair
//            (BF1 + BF2 + twiddle). Optional counters: SDF_STAGE_CTRL_FRAMECNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module sdf_stage_ctrl #(
    parameter int N     = 64,
    parameter int STAGE = 0,
    parameter int PIPE  = 1,
    parameter int AW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          zero_in,
    output logic          bf1_sel,
    output logic          bf2_sel,
    output logic          negj_sel,
    output logic [AW-1:0] tw_addr,
    output logic          out_valid,
    output logic          out_sop,
    output logic          err,
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
    output logic [15:0]   frame_cnt,
    output logic [7:0]    gap_cnt,
`endif
    output logic          busy
);

    localparam int c_m   = N >> (2 * STAGE);
    localparam int c_l   = $clog2(c_m);
    localparam int c_lat = c_m / 2 + c_m / 4 + PIPE;

    localparam logic [c_l-1:0] c_one   = c_l'(1);
    localparam logic [c_l-1:0] c_last  = c_l'(c_m - 1);
    localparam logic [c_l-1:0] c_d2    = c_l'(c_m / 4);
    localparam logic [c_l-1:0] c_d2x2  = c_l'(c_m / 2);
    localparam logic [c_l-1:0] c_d2x3  = c_l'(3 * c_m / 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_l-1:0]   r_c, w_c_nxt, w_c_eff, w_c_d2, w_c_tw, w_kr;
    logic [1:0]       w_k;
    logic [AW-1:0]    w_tw, r_tw;
    logic [c_lat-1:0] r_vld_sr, r_sop_sr;
    logic             r_armed, r_err;
    logic             w_start, w_issue, w_zero, w_err_evt, w_active, w_last, w_bf2_d;

    assign w_active = (r_state != S_IDLE);
    assign w_last   = (r_c == c_last);
    // A new frame may only open from IDLE/FLUSH, and never on the first edge after reset
    assign w_start  = in_valid & in_sop & r_armed & (r_state != S_RUN);
    assign w_c_eff  = w_start ? '0 : r_c;

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c + c_one;
        w_issue     = 1'b0;
        w_zero      = 1'b0;
        w_err_evt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_c_nxt = '0;
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_c_nxt     = c_one;
                    w_issue     = 1'b1;
                end
            end
            S_RUN: begin
                // Index 0 of every frame is taken in IDLE/FLUSH, so any sop seen here is misaligned
                w_issue   = 1'b1;
                w_zero    = ~in_valid;
                w_err_evt = (~in_valid & ~w_last) | (in_valid & in_sop);
                if (w_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_c_nxt     = c_one;
                    w_issue     = 1'b1;
                end else begin
                    w_zero = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_c_nxt     = '0;
            end
        endcase
    end

    // bf2 select of the sample now leaving the D2 line: bit L-2 of (c - D2) by range compare
    assign w_c_d2  = w_c_eff - c_d2;
    assign w_bf2_d = ((w_c_d2 >= c_d2) && (w_c_d2 < c_d2x2)) || (w_c_d2 >= c_d2x3);

    assign bf1_sel  = w_active & w_c_eff[c_l-1];
    assign bf2_sel  = w_active & w_c_eff[c_l-2];
    assign negj_sel = w_active & w_c_eff[c_l-1] & ~w_c_eff[c_l-2] & w_bf2_d;

    assign w_c_tw = w_c_eff - c_d2x3;
    assign w_k    = {w_c_tw[c_l-2], w_c_tw[c_l-1]};

    generate
        if (c_l >= 3) begin : g_tw_kr
            assign w_kr = {{(c_l-2){1'b0}}, w_k} * {2'b00, w_c_tw[c_l-3:0]};
        end else begin : g_tw_zero
            assign w_kr = '0;
        end
    endgenerate

    assign w_tw = AW'(w_kr) << (2 * STAGE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_c      <= '0;
            r_armed  <= 1'b0;
            r_err    <= 1'b0;
            r_tw     <= '0;
            r_vld_sr <= '0;
            r_sop_sr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_c      <= w_c_nxt;
            r_armed  <= 1'b1;
            r_err    <= r_err | w_err_evt;
            r_tw     <= (w_active | w_start) ? w_tw : '0;
            r_vld_sr <= {r_vld_sr[c_lat-2:0], w_issue};
            r_sop_sr <= {r_sop_sr[c_lat-2:0], w_start};
        end
    end

    assign zero_in   = w_zero;
    assign tw_addr   = r_tw;
    assign out_valid = r_vld_sr[c_lat-1];
    assign out_sop   = r_sop_sr[c_lat-1];
    assign err       = r_err;
    assign busy      = w_active;

`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (r_sop_sr[c_lat-1]) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err_evt && (r_gap_cnt != 8'hFF)) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign gap_cnt   = r_gap_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sdf_stage_ctrl
// Purpose  : Directed self-checking bench, N=64 and N=16 instances, STAGE=0, PIPE=1
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic       a_valid = 1'b0, a_sop = 1'b0, b_valid = 1'b0, b_sop = 1'b0;
    logic       a_zero, a_bf1, a_bf2, a_negj, a_ov, a_os, a_err, a_busy;
    logic       b_zero, b_bf1, b_bf2, b_negj, b_ov, b_os, b_err, b_busy;
    logic [5:0] a_tw;
    logic [3:0] b_tw;
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
    logic [15:0] a_frame, b_frame;
    logic [7:0]  a_gap, b_gap;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sdf_stage_ctrl #(.N(64), .STAGE(0), .PIPE(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_sop(a_sop),
        .zero_in(a_zero), .bf1_sel(a_bf1), .bf2_sel(a_bf2), .negj_sel(a_negj),
        .tw_addr(a_tw), .out_valid(a_ov), .out_sop(a_os), .err(a_err),
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
        .frame_cnt(a_frame), .gap_cnt(a_gap),
`endif
        .busy(a_busy)
    );

    sdf_stage_ctrl #(.N(16), .STAGE(0), .PIPE(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_sop(b_sop),
        .zero_in(b_zero), .bf1_sel(b_bf1), .bf2_sel(b_bf2), .negj_sel(b_negj),
        .tw_addr(b_tw), .out_valid(b_ov), .out_sop(b_os), .err(b_err),
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
        .frame_cnt(b_frame), .gap_cnt(b_gap),
`endif
        .busy(b_busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b0; a_sop = 1'b0; b_valid = 1'b0; b_sop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        a_valid = 1'b1; a_sop = 1'b1; b_valid = 1'b1; b_sop = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({a_zero, a_bf1, a_bf2, a_negj, a_tw, a_ov, a_os, a_err, a_busy} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_a_outputs: got %b want 0", {a_zero, a_bf1, a_bf2, a_negj, a_tw, a_ov, a_os, a_err, a_busy});
        end
        n_cmp++;
        if ({b_zero, b_bf1, b_bf2, b_negj, b_tw, b_ov, b_os, b_err, b_busy} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_b_outputs: got %b want 0", {b_zero, b_bf1, b_bf2, b_negj, b_tw, b_ov, b_os, b_err, b_busy});
        end
        // sop held high across the first edge after release must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; a_sop = 1'b0; b_valid = 1'b0; b_sop = 1'b0;
        #1;
        n_cmp++;
        if ({a_busy, b_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release_sop_busy: got %b want 00", {a_busy, b_busy});
        end
        cnt = 0;
        repeat (70) begin
            @(negedge clk); #1;
            if (a_ov | a_os | a_busy | b_ov | b_os | b_busy) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL reset_release_no_output: got %0d active cycles want 0", cnt);
        end
    endtask

    task automatic test_single_frame();
        logic [2:0] e_sel;
        logic [1:0] e_out;
        logic       e_zero, e_busy;
        int         ec;
        do_reset();
        for (int j = 0; j < 140; j++) begin
            a_valid = (j < 64); a_sop = (j == 0);
            #1;
            ec     = j % 64;
            e_sel  = (j < 128) ? {ec[5], ec[4], (ec >= 32 && ec < 48)} : 3'b000;
            e_zero = (j >= 64 && j < 128);
            e_busy = (j >= 1 && j < 128);
            e_out  = {(j >= 49 && j <= 112), (j == 49)};
            n_cmp++;
            if ({a_bf1, a_bf2, a_negj} !== e_sel) begin
                n_bad++;
                $display("FAIL sf_sel j=%0d: got %b want %b", j, {a_bf1, a_bf2, a_negj}, e_sel);
            end
            n_cmp++;
            if ({a_zero, a_busy} !== {e_zero, e_busy}) begin
                n_bad++;
                $display("FAIL sf_zero_busy j=%0d: got %b want %b", j, {a_zero, a_busy}, {e_zero, e_busy});
            end
            n_cmp++;
            if ({a_ov, a_os} !== e_out) begin
                n_bad++;
                $display("FAIL sf_out j=%0d: got %b want %b", j, {a_ov, a_os}, e_out);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL sf_err: got %b want 0", a_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e_out, e_sel;
        logic       e_zero, e_busy;
        int         ec;
        do_reset();
        for (int j = 0; j < 200; j++) begin
            a_valid = (j < 128); a_sop = (j == 0 || j == 64);
            #1;
            ec     = j % 64;
            e_sel  = (j < 192) ? {ec[5], ec[4]} : 2'b00;
            e_zero = (j >= 128 && j < 192);
            e_busy = (j >= 1 && j < 192);
            e_out  = {(j >= 49 && j <= 176), (j == 49 || j == 113)};
            n_cmp++;
            if ({a_bf1, a_bf2, a_zero, a_busy} !== {e_sel, e_zero, e_busy}) begin
                n_bad++;
                $display("FAIL b2b_ctrl j=%0d: got %b want %b", j, {a_bf1, a_bf2, a_zero, a_busy}, {e_sel, e_zero, e_busy});
            end
            n_cmp++;
            if ({a_ov, a_os} !== e_out) begin
                n_bad++;
                $display("FAIL b2b_out j=%0d: got %b want %b", j, {a_ov, a_os}, e_out);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_err: got %b want 0", a_err);
        end
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
        n_cmp++;
        if (a_frame !== 16'd2) begin
            n_bad++;
            $display("FAIL b2b_frame_cnt: got %0d want 2", a_frame);
        end
`endif
    endtask

    task automatic test_gap();
        logic       e_zero, e_err, e_bf1;
        int         n_ov;
        do_reset();
        n_ov = 0;
        for (int j = 0; j < 140; j++) begin
            a_valid = (j < 64 && j != 10); a_sop = (j == 0);
            #1;
            e_zero = (j == 10) || (j >= 64 && j < 128);
            e_err  = (j >= 11);
            e_bf1  = (j < 128) && ((j % 64) >= 32);
            if (a_ov) n_ov++;
            n_cmp++;
            if ({a_zero, a_err, a_bf1} !== {e_zero, e_err, e_bf1}) begin
                n_bad++;
                $display("FAIL gap_ctrl j=%0d: got %b want %b", j, {a_zero, a_err, a_bf1}, {e_zero, e_err, e_bf1});
            end
            n_cmp++;
            if (a_ov !== (j >= 49 && j <= 112)) begin
                n_bad++;
                $display("FAIL gap_out_valid j=%0d: got %b want %b", j, a_ov, (j >= 49 && j <= 112));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n_ov != 64) begin
            n_bad++;
            $display("FAIL gap_ov_count: got %0d want 64", n_ov);
        end
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
        n_cmp++;
        if (a_gap !== 8'd1) begin
            n_bad++;
            $display("FAIL gap_cnt: got %0d want 1", a_gap);
        end
`endif
    endtask

    task automatic test_sop_in_flush();
        logic [1:0] e_out, e_sel;
        logic       e_zero, e_busy;
        int         ec;
        do_reset();
        for (int j = 0; j < 230; j++) begin
            a_valid = (j < 64) || (j >= 84 && j < 148);
            a_sop   = (j == 0 || j == 84);
            #1;
            ec     = (j < 84) ? (j % 64) : ((j - 84) % 64);
            e_sel  = (j < 212) ? {ec[5], ec[4]} : 2'b00;
            e_zero = (j >= 64 && j < 84) || (j >= 148 && j < 212);
            e_busy = (j >= 1 && j < 212);
            e_out  = {(j >= 49 && j <= 112) || (j >= 133 && j <= 196), (j == 49 || j == 133)};
            n_cmp++;
            if ({a_bf1, a_bf2, a_zero, a_busy} !== {e_sel, e_zero, e_busy}) begin
                n_bad++;
                $display("FAIL flush_ctrl j=%0d: got %b want %b", j, {a_bf1, a_bf2, a_zero, a_busy}, {e_sel, e_zero, e_busy});
            end
            n_cmp++;
            if ({a_ov, a_os} !== e_out) begin
                n_bad++;
                $display("FAIL flush_out j=%0d: got %b want %b", j, {a_ov, a_os}, e_out);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_err: got %b want 0", a_err);
        end
`ifdef SDF_STAGE_CTRL_FRAMECNT_EN
        n_cmp++;
        if (a_frame !== 16'd2) begin
            n_bad++;
            $display("FAIL flush_frame_cnt: got %0d want 2", a_frame);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        do_reset();
        for (int j = 0; j < 37; j++) begin
            a_valid = 1'b1; a_sop = (j == 0);
            @(negedge clk);
        end
        a_sop = 1'b0;
        #1;
        n_cmp++;
        if ({a_bf1, a_busy, a_tw} !== {1'b1, 1'b1, 6'd12}) begin
            n_bad++;
            $display("FAIL midrun_pre: got bf1/busy/tw %b/%b/%0d want 1/1/12", a_bf1, a_busy, a_tw);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_zero, a_bf1, a_bf2, a_negj, a_tw, a_ov, a_os, a_err, a_busy} !== 14'd0) begin
            n_bad++;
            $display("FAIL midrun_async_clear: got %b want 0", {a_zero, a_bf1, a_bf2, a_negj, a_tw, a_ov, a_os, a_err, a_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (80) begin
            @(negedge clk); #1;
            if (a_ov | a_os | a_busy) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL midrun_no_output: got %0d active cycles want 0", cnt);
        end
        @(negedge clk);
        for (int j = 0; j < 60; j++) begin
            a_valid = 1'b1; a_sop = (j == 0);
            #1;
            n_cmp++;
            if ({a_ov, a_os} !== {(j >= 49), (j == 49)}) begin
                n_bad++;
                $display("FAIL midrun_restart j=%0d: got %b want %b", j, {a_ov, a_os}, {(j >= 49), (j == 49)});
            end
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_twiddle();
        int tw_exp[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
        int idx;
        do_reset();
        idx = 0;
        for (int j = 0; j < 60; j++) begin
            b_valid = (j < 32); b_sop = (j == 0 || j == 16);
            #1;
            n_cmp++;
            if ({b_ov, b_os} !== {(j >= 13 && j <= 44), (j == 13 || j == 29)}) begin
                n_bad++;
                $display("FAIL tw_out j=%0d: got %b want %b", j, {b_ov, b_os}, {(j >= 13 && j <= 44), (j == 13 || j == 29)});
            end
            if (j == 16) begin
                n_cmp++;
                if (b_zero !== 1'b0) begin
                    n_bad++;
                    $display("FAIL tw_b2b_zero: got %b want 0", b_zero);
                end
            end
            if (b_ov === 1'b1) begin
                n_cmp++;
                if (b_tw !== 4'(tw_exp[idx % 16])) begin
                    n_bad++;
                    $display("FAIL tw_addr sample=%0d: got %0d want %0d", idx, b_tw, tw_exp[idx % 16]);
                end
                idx++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (idx != 32) begin
            n_bad++;
            $display("FAIL tw_count: got %0d want 32", idx);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_sop_in_flush();
        test_reset_mid_run();
        test_twiddle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencer for one radix-2^2 single-path delay-feedback (22SDF) FFT stage pair (BF1 + BF2 + twiddle multiply).
- The feedback delay lines shift unconditionally every clock, so this block owns the stage's local sample counter.
- From that counter it drives the BF1/BF2 switch selects, the trivial -j rotation select, the twiddle ROM address and the output valid/start-of-frame.
- It also sequences a zero-fill flush so the last frame drains out of the delay lines when input stops.

Parameters:
- N, 64: FFT length; power of 4, 16..4096.
- STAGE, 0: stage-pair index s. Local length M = N/4^s, D1 = M/2, D2 = M/4. M >= 4 required.
- PIPE, 1: fixed register latency of butterfly plus multiplier datapath, 0..4 cycles.
- AW, log2(N): twiddle address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample present this cycle
- in_sop  in  1  first sample of a frame; qualified by in_valid
- zero_in  out  1  datapath must substitute 0+j0 for the input sample this cycle
- bf1_sel  out  1  BF1 switch: 0 = fill delay line, 1 = butterfly
- bf2_sel  out  1  BF2 switch, same encoding
- negj_sel  out  1  apply -j rotation at BF2 input
- tw_addr  out  AW  twiddle ROM address, W_N^tw_addr
- out_valid  out  1  stage output sample valid
- out_sop  out  1  stage output first sample of frame
- err  out  1  sticky stream-gap error
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert at the block boundary):
  - state = IDLE, counter c = 0.
  - All outputs 0, err = 0, valid/sop shift registers cleared.
- Counter c is log2(M) bits wide. L = log2(M).
- States:
  - IDLE: c held at 0. in_valid & in_sop -> RUN; c = 1 on the next cycle, because the sop sample is counted as index 0 this cycle. in_valid without in_sop is ignored.
  - RUN: c increments every clock, modulo M.
    - At c == M-1: next cycle with in_valid & in_sop stays RUN (c wraps to 0). Next cycle without in_valid goes to FLUSH.
    - in_valid = 0 while c != M-1 sets err; the sample is zero-filled (zero_in = 1) and counting continues.
    - in_sop while c != 0 sets err; c is not realigned.
  - FLUSH: c keeps incrementing; zero_in = 1 for exactly M cycles.
    - At the end of the M cycles -> IDLE.
    - in_valid & in_sop during FLUSH: abort the flush, c = 0, go to RUN. Flushed samples already issued remain valid.
- Combinational decodes from c, valid in RUN and FLUSH; forced to 0 in IDLE:
  - bf1_sel = c[L-1].
  - bf2_sel = c[L-2].
  - negj_sel = c[L-1] & ~c[L-2] & bf2_sel_d. Here bf2_sel_d is c[L-2] of the sample leaving the D2 delay line, which is equivalent to c[L-2] delayed by D2. Implement it with a counter compare, not a shift register.
- tw_addr:
  - k = {c[L-2], c[L-1]} (bit-reversed quarter index: 0,2,1,3), r = c[L-3:0].
  - tw_addr = (k*r) << (2*s), truncated to AW bits.
  - Registered, and aligned to the datapath sample leaving BF2, i.e. computed from c - (D1+D2) mod M.
- Latency:
  - LAT = D1 + D2 + PIPE.
  - out_valid = RUN/FLUSH sample issued LAT cycles earlier, but only for samples belonging to a frame whose sop was accepted.
  - out_sop = in_sop accepted LAT cycles earlier.
  - The pure zero-fill samples of FLUSH never produce out_valid. Exactly M out_valid pulses per accepted frame.
- Simultaneous in_sop with reset deassertion: ignored on the first cycle after deassertion.
- Reset mid-frame: immediate clear; in-flight outputs are dropped.
- err clears only on reset.

Optional Feature:
- Macro: SDF_STAGE_CTRL_FRAMECNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], incremented on each out_sop; wraps at 0xFFFF -> 0; reset 0.
  - Adds output gap_cnt [7:0], incremented on every err-setting event, saturating at 0xFF.
- Undefined: ports absent, no counters.

Test Plan:
- N=64, STAGE=0, PIPE=1, reset release, single frame of 64 contiguous valid samples starting with sop:
  - bf1_sel rises at c=32; bf2_sel toggles every 16 cycles.
  - out_sop 49 cycles after input sop.
  - 64 out_valid pulses, then FLUSH of 64 cycles, then busy = 0.
- Back-to-back frames (sop at c=0 of the next frame): no FLUSH entered; out_valid continuous for 128 cycles; frame_cnt = 2 with the macro defined.
- in_valid dropped at c=10 for one cycle: err = 1, zero_in = 1 that cycle, counter still advances, out_valid count for the frame still 64.
- tw_addr check with N=16, STAGE=0: output sequence per frame is 0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9.
- New sop during FLUSH at flush cycle 20: state returns to RUN, c = 0, zero_in deasserts, both frames' outputs are complete and ordered.
- rst_n asserted asynchronously mid-RUN (c=37): all outputs 0 within the same cycle; after release, no out_valid until a new sop.
